// File: rtl/riscv_control_unit.sv
// Multicycle control FSM for the RV64 datapath with a retired-instruction counter.
// Optional macro RISCV_CU_ILLEGAL_TRAP_EN: unsupported instructions halt instead of acting as NOPs.
module riscv_control_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             flag_beq,
    input  logic             flag_bnq,
    input  logic             flag_blt,
    input  logic             flag_bge,
    input  logic             flag_bltu,
    input  logic             flag_bgeu,
    output logic             load_IR,
    output logic             load_PC,
    output logic             we_RF,
    output logic             we_DM,
    output logic             sel_ALU_A,
    output logic             sel_ALU_B,
    output logic             sel_PC_A,
    output logic             sel_PC_B,
    output logic             sel_PC_RF,
    output logic [2:0]       sel_imme,
    output logic [1:0]       sel_RF_in,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    logic is_r, is_i, is_ld, is_st, is_br;
    logic is_jal, is_jalr, is_auipc;
    logic taken;
    logic pc4;
    logic [2:0] imm_op;

    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_ld    = (opcode == OP_LOAD);
    assign is_st    = (opcode == OP_STORE);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_auipc = (opcode == OP_AUIPC);
    assign is_br    = (opcode == OP_BR) &&
                      (func3 != 3'b010) && (func3 != 3'b011);

    always_comb begin
        taken = 1'b0;
        case (func3)
            3'b000:  taken = flag_beq;
            3'b001:  taken = flag_bnq;
            3'b100:  taken = flag_blt;
            3'b101:  taken = flag_bge;
            3'b110:  taken = flag_bltu;
            3'b111:  taken = flag_bgeu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        imm_op = 3'b000;
        if (is_st)                   imm_op = 3'b001;
        else if (opcode == OP_BR)    imm_op = 3'b010;
        else if (is_jal)             imm_op = 3'b011;
        else if (is_auipc)           imm_op = 3'b100;
    end

`ifdef RISCV_CU_ILLEGAL_TRAP_EN
    logic supported;
    logic illegal_q, illegal_d;

    assign supported = is_r | is_i | is_ld | is_st | is_br |
                       is_jal | is_jalr | is_auipc;
`endif

    always_comb begin
        state_d = state_q;
`ifdef RISCV_CU_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
`ifdef RISCV_CU_ILLEGAL_TRAP_EN
            S_DECODE: begin
                if (supported) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_HALT:   state_d = S_HALT;
`else
            S_DECODE: state_d = S_EXEC;
            S_HALT:   state_d = S_FETCH;
`endif
            S_EXEC:   state_d = (is_ld || is_st) ? S_MEM : S_FETCH;
            S_MEM:    state_d = is_ld ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_EXEC) || (state_q == S_MEM) ||
                     (state_q == S_WB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

`ifdef RISCV_CU_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign instret = instret_q;

    // Outputs are gated by rst_n so a reset mid-instruction kills every write at once.
    always_comb begin
        load_IR   = 1'b0;
        load_PC   = 1'b0;
        we_RF     = 1'b0;
        we_DM     = 1'b0;
        sel_ALU_A = 1'b0;
        sel_ALU_B = 1'b0;
        sel_PC_A  = 1'b0;
        sel_PC_B  = 1'b0;
        sel_PC_RF = 1'b0;
        sel_imme  = 3'b000;
        sel_RF_in = 2'b00;
        pc4       = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH:  load_IR  = 1'b1;
                S_DECODE: sel_imme = imm_op;
                S_EXEC: begin
                    unique case (1'b1)
                        is_r: begin
                            sel_ALU_A = 1'b1;
                            sel_ALU_B = 1'b1;
                            we_RF     = 1'b1;
                            pc4       = 1'b1;
                        end
                        is_i: begin
                            sel_ALU_A = 1'b1;
                            we_RF     = 1'b1;
                            pc4       = 1'b1;
                        end
                        is_ld, is_st: begin
                            sel_ALU_A = 1'b1;
                            sel_imme  = imm_op;
                        end
                        is_br: begin
                            if (taken) begin
                                load_PC  = 1'b1;
                                sel_PC_A = 1'b1;
                                sel_imme = imm_op;
                            end else begin
                                pc4 = 1'b1;
                            end
                        end
                        is_jal, is_jalr: begin
                            we_RF     = 1'b1;
                            sel_RF_in = 2'b11;
                            sel_PC_RF = 1'b1;
                            sel_imme  = imm_op;
                            load_PC   = 1'b1;
                            sel_PC_A  = is_jal;
                        end
                        is_auipc: begin
                            we_RF     = 1'b1;
                            sel_RF_in = 2'b11;
                            sel_imme  = imm_op;
                            pc4       = 1'b1;
                        end
                        default: pc4 = 1'b1;
                    endcase
                end
                S_MEM: begin
                    sel_ALU_A = 1'b1;
                    sel_imme  = imm_op;
                    if (is_st) begin
                        we_DM = 1'b1;
                        pc4   = 1'b1;
                    end
                end
                S_WB: begin
                    sel_ALU_A = 1'b1;
                    sel_imme  = imm_op;
                    we_RF     = 1'b1;
                    sel_RF_in = 2'b01;
                    pc4       = 1'b1;
                end
                default: ;
            endcase
            if (pc4) begin
                load_PC  = 1'b1;
                sel_PC_A = 1'b1;
                sel_PC_B = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_control_unit.sv
// Scoreboard bench for riscv_control_unit: a per-instruction model queues the
// expected output bundle for every cycle and a negedge monitor compares it.
module tb_riscv_control_unit;

    localparam int CW     = 4;
    localparam int HALT_N = 20;

    localparam logic [6:0] OR  = 7'b0110011;
    localparam logic [6:0] OI  = 7'b0010011;
    localparam logic [6:0] OL  = 7'b0000011;
    localparam logic [6:0] OS  = 7'b0100011;
    localparam logic [6:0] OB  = 7'b1100011;
    localparam logic [6:0] OJ  = 7'b1101111;
    localparam logic [6:0] OJR = 7'b1100111;
    localparam logic [6:0] OA  = 7'b0010111;
    localparam logic [6:0] LUI = 7'b0110111;

    localparam logic [14:0] LIR = 15'h4000;
    localparam logic [14:0] LPC = 15'h2000;
    localparam logic [14:0] WRF = 15'h1000;
    localparam logic [14:0] WDM = 15'h0800;
    localparam logic [14:0] SA  = 15'h0400;
    localparam logic [14:0] SB  = 15'h0200;
    localparam logic [14:0] PA  = 15'h0100;
    localparam logic [14:0] PB  = 15'h0080;
    localparam logic [14:0] PRF = 15'h0040;
    localparam logic [14:0] IMM = 15'h0038;
    localparam logic [14:0] RFI = 15'h0006;
    localparam logic [14:0] ILL = 15'h0001;
    localparam logic [14:0] EN  = LIR | LPC | WRF | WDM | ILL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic flag_beq = 0, flag_bnq = 0, flag_blt = 0;
    logic flag_bge = 0, flag_bltu = 0, flag_bgeu = 0;
    logic load_IR, load_PC, we_RF, we_DM;
    logic sel_ALU_A, sel_ALU_B, sel_PC_A, sel_PC_B, sel_PC_RF;
    logic [2:0] sel_imme;
    logic [1:0] sel_RF_in;
    logic [CW-1:0] instret;
    logic illegal;

    typedef struct {
        logic [14:0]   v;
        logic [14:0]   m;
        logic [CW-1:0] ir;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int n_chk = 0;
    int n_pass = 0;
    int n_ret = 0;

    riscv_control_unit #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .opcode(opcode), .func3(func3),
        .flag_beq(flag_beq), .flag_bnq(flag_bnq),
        .flag_blt(flag_blt), .flag_bge(flag_bge),
        .flag_bltu(flag_bltu), .flag_bgeu(flag_bgeu),
        .load_IR(load_IR), .load_PC(load_PC),
        .we_RF(we_RF), .we_DM(we_DM),
        .sel_ALU_A(sel_ALU_A), .sel_ALU_B(sel_ALU_B),
        .sel_PC_A(sel_PC_A), .sel_PC_B(sel_PC_B),
        .sel_PC_RF(sel_PC_RF), .sel_imme(sel_imme),
        .sel_RF_in(sel_RF_in), .instret(instret),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] actv();
        return {load_IR, load_PC, we_RF, we_DM, sel_ALU_A, sel_ALU_B,
                sel_PC_A, sel_PC_B, sel_PC_RF, sel_imme, sel_RF_in,
                illegal};
    endfunction

    function automatic logic [14:0] im(input int x);
        return 15'(x) << 3;
    endfunction

    task automatic chk(input string nm, input logic ok,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s actual=%h required=%h t=%0t",
                      nm, act, exp, $time);
    endtask

    task automatic put(input logic [14:0] v, input logic [14:0] m);
        exp_t e;
        e.v  = v;
        e.m  = m;
        e.ir = CW'(n_ret % (1 << CW));
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin
            me = q.pop_front();
            chk("cycle", (((actv() ^ me.v) & me.m) == '0) &&
                         (instret == me.ir),
                {13'd0, instret, actv()}, {13'd0, me.ir, me.v});
        end
    end

    // Reference: the cycle-by-cycle output bundle of one whole instruction.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [5:0] fl);
        logic [14:0] pv, pm;
        logic sup, tk;
        int n;
        opcode = op;
        func3  = f3;
        {flag_beq, flag_bnq, flag_blt, flag_bge, flag_bltu, flag_bgeu} = fl;
        pv = LPC | PA | PB;
        pm = PA | PB;
        sup = (op inside {OR, OI, OL, OS, OJ, OJR, OA}) ||
              (op == OB && f3 != 3'd2 && f3 != 3'd3);
        case (f3)
            3'd0: tk = fl[5];
            3'd1: tk = fl[4];
            3'd4: tk = fl[3];
            3'd5: tk = fl[2];
            3'd6: tk = fl[1];
            3'd7: tk = fl[0];
            default: tk = 1'b0;
        endcase
        put(LIR, EN);
        case (op)
            OI, OL, OJR: put(im(0), EN | IMM);
            OS:          put(im(1), EN | IMM);
            OB:          put(im(2), EN | IMM);
            OJ:          put(im(3), EN | IMM);
            OA:          put(im(4), EN | IMM);
            default:     put('0, EN);
        endcase
        if (!sup) begin
`ifdef RISCV_CU_ILLEGAL_TRAP_EN
            repeat (HALT_N) put(ILL, EN);
`else
            put(pv, EN | pm);
            n_ret++;
`endif
        end else begin
            case (op)
                OR: put(SA | SB | WRF | pv, EN | SA | SB | RFI | pm);
                OI: put(SA | WRF | im(0) | pv,
                        EN | SA | SB | IMM | RFI | pm);
                OL: begin
                    put(SA | im(0), EN | SA | SB | IMM);
                    put('0, EN);
                    put(WRF | 15'h0002 | SA | im(0) | pv,
                        EN | RFI | SA | SB | IMM | pm);
                end
                OS: begin
                    put(SA | im(1), EN | SA | SB | IMM);
                    put(WDM | SA | im(1) | pv, EN | SA | SB | IMM | pm);
                end
                OB: begin
                    if (tk) put(LPC | PA | im(2), EN | PA | PB | IMM);
                    else    put(pv, EN | pm);
                end
                OJ:  put(WRF | RFI | PRF | im(3) | LPC | PA,
                         EN | RFI | PRF | IMM | PA | PB);
                OJR: put(WRF | RFI | PRF | im(0) | LPC,
                         EN | RFI | PRF | IMM | PA | PB);
                default: put(WRF | RFI | im(4) | pv,
                             EN | RFI | PRF | IMM | pm);
            endcase
            n_ret++;
        end
        n = q.size();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [2:0] bf3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [6:0] ops [8] = '{OR, OI, OL, OS, OB, OJ, OJR, OA};

    initial begin
        #2;
        chk("reset_outputs", actv() == '0 && instret == '0,
            {13'd0, instret, actv()}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(OR, 3'd0, 6'd0);
        issue(OL, 3'd2, 6'd0);
        issue(OS, 3'd3, 6'd0);
        issue(OB, 3'd1, 6'b010000);
        issue(OB, 3'd1, 6'b101111);
        issue(OJR, 3'd0, 6'd0);
        issue(OJ, 3'd0, 6'd0);
        issue(OA, 3'd0, 6'd0);
        issue(OI, 3'd5, 6'd0);
`ifndef RISCV_CU_ILLEGAL_TRAP_EN
        issue(LUI, 3'd0, 6'd0);
        issue(OB, 3'd2, 6'h3f);
`endif

        for (int i = 0; i < 150; i++) begin
            logic [6:0] op;
            logic [2:0] f3;
            int k;
            k  = $urandom_range(0, 10);
            f3 = 3'($urandom_range(0, 7));
`ifdef RISCV_CU_ILLEGAL_TRAP_EN
            k = k % 8;
`endif
            if (k < 8)       op = ops[k];
            else if (k == 8) op = LUI;
            else if (k == 9) op = OB;
            else             op = 7'($urandom_range(0, 127));
`ifdef RISCV_CU_ILLEGAL_TRAP_EN
            if (op == OB) f3 = bf3[$urandom_range(0, 5)];
`endif
            issue(op, f3, 6'($urandom_range(0, 63)));
        end

        opcode = OR;
        func3  = 3'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("exec_before_reset", we_RF == 1'b1, {31'd0, we_RF}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_exec", actv() == '0 && instret == '0,
            {13'd0, instret, actv()}, 32'd0);
        n_ret = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(OR, 3'd0, 6'd0);
        issue(OL, 3'd0, 6'd0);

`ifdef RISCV_CU_ILLEGAL_TRAP_EN
        issue(LUI, 3'd0, 6'd0);
`endif
        @(negedge clk);
        chk("queue_drained", q.size() == 0, 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/riscv_control_unit.md
Name: riscv_control_unit

Overview:
- Multicycle control FSM (UC) for the RV64 datapath.
- Consumes opcode, func3 and the ALU branch flags from the datapath.
- Drives every datapath load/enable/mux-select, plus the data-memory write enable.
- Keeps a retired-instruction counter for bring-up and debug.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- opcode  input  7  IR[6:0] from the datapath.
- func3  input  3  IR[14:12] from the datapath.
- flag_beq, flag_bnq, flag_blt, flag_bge, flag_bltu, flag_bgeu  input  1 each  ALU compare flags for the current rs1/rs2.
- load_IR  output  1  IR capture enable.
- load_PC  output  1  PC load enable.
- we_RF  output  1  register-file write enable.
- we_DM  output  1  data-memory write enable.
- sel_ALU_A  output  1  1 = rs1, 0 = immediate.
- sel_ALU_B  output  1  1 = rs2, 0 = immediate.
- sel_PC_A  output  1  1 = PC, 0 = rs1[19:0].
- sel_PC_B  output  1  1 = constant 4, 0 = immediate.
- sel_PC_RF  output  1  1 = PC+4, 0 = PC+imm.
- sel_imme  output  3  immediate select: 000 I, 001 S, 010 B, 011 J, 100 U.
- sel_RF_in  output  2  RF write source: 00 ALU, 01 DM, 11 PC_RF.
- instret  output  CNT_W  retired-instruction count.
- illegal  output  1  illegal instruction flag.

Behaviour:
- Reset: asynchronous, active-low (rst_n low forces reset immediately, independent of clk).
  - While rst_n is low: state = FETCH, instret = 0, illegal = 0, all enables 0, all selects 0.
  - Reset asserted mid-instruction aborts it with no RF, DM or PC write.
- Output timing: outputs are combinational from the registered state, opcode, func3 and flags. Enables are high for exactly one cycle per state visit.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: load_IR = 1. Next state DECODE.
- DECODE: no enables asserted. sel_imme is driven for the opcode.
  - Supported opcode: next state EXEC.
  - Unsupported opcode: see Optional Feature.
- Supported opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0010111 AUIPC.
  - LUI (0110111) is unsupported.
  - BRANCH with func3 010 or 011 is unsupported.
- Standard "PC+4" update: load_PC = 1, sel_PC_A = 1, sel_PC_B = 1.
- EXEC actions by opcode:
  - R: sel_ALU_A = 1, sel_ALU_B = 1, we_RF = 1, sel_RF_in = 00, PC+4. Next state FETCH.
  - I-ALU: sel_ALU_A = 1, sel_ALU_B = 0, sel_imme = 000, we_RF = 1, sel_RF_in = 00, PC+4. Next state FETCH.
  - LOAD: address = rs1 + I-immediate (sel_ALU_A = 1, sel_ALU_B = 0, sel_imme = 000). Next state MEM.
  - STORE: same address setup with sel_imme = 001. Next state MEM.
  - BRANCH: flag chosen by func3 (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu). load_PC = 1.
    - Taken: sel_PC_A = 1, sel_PC_B = 0, sel_imme = 010.
    - Not taken: PC+4.
    - Next state FETCH.
  - JAL: we_RF = 1, sel_RF_in = 11, sel_PC_RF = 1, sel_imme = 011, load_PC = 1, sel_PC_A = 1, sel_PC_B = 0. Next state FETCH.
  - JALR: as JAL but sel_imme = 000 and sel_PC_A = 0. Next state FETCH.
  - AUIPC: we_RF = 1, sel_RF_in = 11, sel_PC_RF = 0, sel_imme = 100, PC+4. Next state FETCH.
  - RF write and PC load share the same edge, so the RF captures PC-based values from the old PC.
- MEM:
  - STORE: we_DM = 1 (ALU address held), PC+4. Next state FETCH.
  - LOAD: no enables. Next state WB.
- WB (LOAD only): we_RF = 1, sel_RF_in = 01, ALU address held, PC+4. Next state FETCH.
- Latency, FETCH to FETCH: 3 cycles for R, I-ALU, BRANCH, JAL, JALR, AUIPC; 4 for STORE; 5 for LOAD.
- instret: increments by 1 on every transition into FETCH from EXEC, MEM or WB. Wraps modulo 2^CNT_W with no flag.

Optional Feature:
- Macro: RISCV_CU_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode or func3 in DECODE sets illegal = 1 and moves to HALT.
  - HALT asserts no enables and never exits until rst_n is low.
  - instret is frozen while in HALT.
- Undefined: an unsupported instruction executes as a NOP.
  - EXEC does PC+4 only and increments instret.
  - illegal is tied to 0; HALT is unreachable.

Test Plan:
- Reset: rst_n low mid-EXEC of an R-type -> all enables 0 in the same cycle, state FETCH, instret 0; after release the first cycle has load_IR = 1.
- R-type 0110011 -> we_RF = 1 for exactly 1 cycle with sel_ALU_A = 1, sel_ALU_B = 1, sel_RF_in = 00; load_PC with PC+4 selects; instret 0 -> 1 after 3 cycles.
- LOAD 0000011 -> 5-cycle sequence; we_RF = 1 only in WB with sel_RF_in = 01; we_DM never asserted. STORE 0100011 -> we_DM = 1 only in MEM, sel_imme = 001 in EXEC.
- BRANCH func3 = 001: flag_bnq = 1 -> sel_PC_B = 0, sel_imme = 010; flag_bnq = 0 -> sel_PC_B = 1. Both cases have load_PC = 1 and we_RF = 0.
- JALR 1100111 -> in EXEC: we_RF = 1, sel_RF_in = 11, sel_PC_RF = 1, sel_PC_A = 0, sel_PC_B = 0, sel_imme = 000.
- LUI 0110111 with RISCV_CU_ILLEGAL_TRAP_EN -> illegal = 1, state HALT, no enables for 20 cycles, instret unchanged. Without the macro -> PC+4, instret + 1, illegal = 0.
